// File: rtl/bp_be_sv39_walker_pkg.sv
// Shared Sv39 walker types: PTE layout, TLB leaf entry, walker states and the
// single combinational PTE decode / superpage-splinter function.
package bp_be_sv39_walker_pkg;

  localparam int page_offset_width_gp = 12;
  localparam int vpn_width_gp         = 9;
  localparam int sv39_levels_gp       = 3;
  localparam int sv39_ppn_width_gp    = 44;
  localparam int sv39_vaddr_width_gp  = 39;
  localparam int sv39_paddr_width_gp  = 40;
  localparam int sv39_vtag_width_gp   = sv39_vaddr_width_gp - page_offset_width_gp;
  localparam int sv39_ptag_width_gp   = sv39_paddr_width_gp - page_offset_width_gp;
  localparam int sv39_entry_width_gp  = sv39_ptag_width_gp + 6;

  typedef struct packed {
    logic [9:0]                   reserved;
    logic [sv39_ppn_width_gp-1:0] ppn;
    logic [1:0]                   rsw;
    logic                         d;
    logic                         a;
    logic                         g;
    logic                         u;
    logic                         x;
    logic                         w;
    logic                         r;
    logic                         v;
  } sv39_pte_t;

  // Leaf entry in the layout the TLB write ports and the trace monitor consume.
  typedef struct packed {
    logic [sv39_ptag_width_gp-1:0] ptag;
    logic                          a;
    logic                          d;
    logic                          u;
    logic                          x;
    logic                          w;
    logic                          r;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FILL  = 3'd4,
    ST_FAULT = 3'd5
  } walker_state_e;

  typedef struct packed {
    logic                          fault;
    logic                          leaf;
    logic [sv39_ptag_width_gp-1:0] next_ppn;
    tlb_entry_t                    entry;
  } pte_decode_t;

  function automatic pte_decode_t decode_pte(
    input logic [63:0]                   pte_raw,
    input logic [1:0]                    level,
    input logic [sv39_vtag_width_gp-1:0] vtag,
    input logic                          store
  );
    sv39_pte_t                     pte;
    pte_decode_t                   res;
    logic [sv39_ptag_width_gp-1:0] leaf_ptag;
    logic                          misaligned;
    logic                          ppn_overflow;
    pte          = sv39_pte_t'(pte_raw);
    ppn_overflow = |pte.ppn[sv39_ppn_width_gp-1:sv39_ptag_width_gp];
    // Superpages are splintered into a 4 KiB entry using the missing vtag's low VPN bits.
    case (level)
      2'd2: begin
        misaligned = |pte.ppn[2*vpn_width_gp-1:0];
        leaf_ptag  = {pte.ppn[sv39_ptag_width_gp-1:2*vpn_width_gp], vtag[2*vpn_width_gp-1:0]};
      end
      2'd1: begin
        misaligned = |pte.ppn[vpn_width_gp-1:0];
        leaf_ptag  = {pte.ppn[sv39_ptag_width_gp-1:vpn_width_gp], vtag[vpn_width_gp-1:0]};
      end
      default: begin
        misaligned = 1'b0;
        leaf_ptag  = pte.ppn[sv39_ptag_width_gp-1:0];
      end
    endcase
    res          = '0;
    res.next_ppn = pte.ppn[sv39_ptag_width_gp-1:0];
    res.entry    = '{ptag: leaf_ptag, a: pte.a, d: pte.d, u: pte.u, x: pte.x, w: pte.w, r: pte.r};
    if (!pte.v || (!pte.r && pte.w) || ppn_overflow) begin
      res.fault = 1'b1;
      res.leaf  = 1'b0;
    end else if (pte.r || pte.x) begin
      res.leaf  = 1'b1;
      res.fault = misaligned || !pte.a || (store && !pte.d);
    end else begin
      res.leaf  = 1'b0;
      res.fault = (level == 2'd0);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_be_sv39_walker.sv
// Sv39 hardware page-table walker: one ITLB/DTLB miss at a time, up to three
// PTE loads over a single-outstanding port, ending in a one-cycle fill or fault.
module bp_be_sv39_walker
  import bp_be_sv39_walker_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int paddr_width_p = 40
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [paddr_width_p-13:0]        base_ppn_i,
  input  logic                             flush_i,
  input  logic                             miss_v_i,
  input  logic                             miss_instr_i,
  input  logic                             miss_store_i,
  input  logic [vaddr_width_p-13:0]        miss_vtag_i,
  output logic                             ready_o,
  output logic                             mem_req_v_o,
  output logic [paddr_width_p-1:0]         mem_req_paddr_o,
  input  logic                             mem_req_ready_i,
  input  logic                             mem_resp_v_i,
  input  logic [63:0]                      mem_resp_data_i,
  output logic                             itlb_fill_v_o,
  output logic                             dtlb_fill_v_o,
  output logic [vaddr_width_p-13:0]        fill_vtag_o,
  output logic [paddr_width_p-12+6-1:0]    fill_entry_o,
  output logic                             page_fault_v_o,
  output logic                             fault_instr_o
);

  walker_state_e                 state_q, state_d;
  logic [1:0]                    level_q, level_d;
  logic [sv39_ptag_width_gp-1:0] ppn_q, ppn_d;
  logic [sv39_vtag_width_gp-1:0] vtag_q, vtag_d;
  logic                          instr_q, instr_d;
  logic                          store_q, store_d;
  tlb_entry_t                    entry_q, entry_d;

  logic                          ready_q;
  logic                          mem_req_v_q;
  logic [paddr_width_p-1:0]      mem_req_paddr_q, mem_req_paddr_d;
  logic                          itlb_fill_q, dtlb_fill_q;
  logic                          fault_v_q, fault_instr_q;

  pte_decode_t                   pte_dec_s;
  logic [vpn_width_gp-1:0]       vpn_s;

  assign pte_dec_s = decode_pte(mem_resp_data_i, level_q, vtag_q, store_q);

  // Next-state logic for the walk FSM and its working registers.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ppn_d   = ppn_q;
    vtag_d  = vtag_q;
    instr_d = instr_q;
    store_d = store_q;
    entry_d = entry_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_v_i && !flush_i) begin
          state_d = ST_SEND;
          level_d = 2'd2;
          ppn_d   = base_ppn_i;
          vtag_d  = miss_vtag_i;
          instr_d = miss_instr_i;
          store_d = miss_store_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (flush_i) begin
          state_d = mem_req_ready_i ? ST_DRAIN : ST_IDLE;
        end else if (mem_req_ready_i) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        // A flush coinciding with the response has nothing left to drain.
        if (flush_i) begin
          state_d = mem_resp_v_i ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_v_i) begin
          if (pte_dec_s.fault) begin
            state_d = ST_FAULT;
          end else if (pte_dec_s.leaf) begin
            state_d = ST_FILL;
            entry_d = pte_dec_s.entry;
          end else begin
            state_d = ST_SEND;
            level_d = level_q - 2'd1;
            ppn_d   = pte_dec_s.next_ppn;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_v_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FILL:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // PTE address for the level being fetched next.
  always_comb begin
    case (level_d)
      2'd2:    vpn_s = vtag_d[2*vpn_width_gp +: vpn_width_gp];
      2'd1:    vpn_s = vtag_d[vpn_width_gp +: vpn_width_gp];
      default: vpn_s = vtag_d[vpn_width_gp-1:0];
    endcase
    mem_req_paddr_d = paddr_width_p'({ppn_d, vpn_s, 3'b000});
  end

  // Walk state, working registers and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      level_q         <= 2'd0;
      ppn_q           <= '0;
      vtag_q          <= '0;
      instr_q         <= 1'b0;
      store_q         <= 1'b0;
      entry_q         <= '0;
      ready_q         <= 1'b1;
      mem_req_v_q     <= 1'b0;
      mem_req_paddr_q <= '0;
      itlb_fill_q     <= 1'b0;
      dtlb_fill_q     <= 1'b0;
      fault_v_q       <= 1'b0;
      fault_instr_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      ppn_q           <= ppn_d;
      vtag_q          <= vtag_d;
      instr_q         <= instr_d;
      store_q         <= store_d;
      entry_q         <= entry_d;
      ready_q         <= (state_d == ST_IDLE);
      mem_req_v_q     <= (state_d == ST_SEND);
      mem_req_paddr_q <= mem_req_paddr_d;
      itlb_fill_q     <= (state_d == ST_FILL) && instr_d;
      dtlb_fill_q     <= (state_d == ST_FILL) && !instr_d;
      fault_v_q       <= (state_d == ST_FAULT);
      fault_instr_q   <= (state_d == ST_FAULT) && instr_d;
    end
  end

  assign ready_o         = ready_q;
  assign mem_req_v_o     = mem_req_v_q;
  assign mem_req_paddr_o = mem_req_paddr_q;
  // A flush landing on the strobe cycle must keep a stale translation out of the TLBs.
  assign itlb_fill_v_o   = itlb_fill_q && !flush_i;
  assign dtlb_fill_v_o   = dtlb_fill_q && !flush_i;
  assign page_fault_v_o  = fault_v_q && !flush_i;
  assign fault_instr_o   = fault_instr_q;
  assign fill_vtag_o     = vtag_q;
  assign fill_entry_o    = entry_q;

endmodule
